// File: rtl/uart_rx_ctrl_if.sv
// Receive-controller signal bundle: raw serial line in, shift/load strobes and status out.
// master = the controller, slave = the shift register / status consumer.
interface uart_rx_ctrl_if;
   logic serin;
   logic sdata;
   logic en;
   logic charReceive;
   logic busy;
   logic frameErr;
   logic parErr;

   modport master (input serin, output sdata, en, charReceive, busy, frameErr, parErr);
   modport slave  (output serin, input sdata, en, charReceive, busy, frameErr, parErr);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises serin, validates the start bit, strobes each data bit
// mid-bit into the shift register, then checks stop. Define RX_PARITY_EN for even-parity checking.
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic           clk,
   input  logic           reset,
   uart_rx_ctrl_if.master rx
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] MID_TICK  = TW'(CLKS_PER_BIT/2 - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state;
   logic [1:0]    sync;
   logic          rx_s;
   logic [TW-1:0] tick_cnt;
   logic [BW-1:0] bit_cnt;
   logic          sdata_r, en_r, char_r, busy_r, ferr_r;
`ifdef RX_PARITY_EN
   logic          perr_r, par_acc, par_bad;
`endif

   assign rx_s = sync[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         sync     <= 2'b11;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         sdata_r  <= 1'b0;
         en_r     <= 1'b0;
         char_r   <= 1'b0;
         busy_r   <= 1'b0;
         ferr_r   <= 1'b0;
`ifdef RX_PARITY_EN
         perr_r   <= 1'b0;
         par_acc  <= 1'b0;
         par_bad  <= 1'b0;
`endif
      end else begin
         sync   <= {sync[0], rx.serin};
         en_r   <= 1'b0;
         char_r <= 1'b0;
         ferr_r <= 1'b0;
`ifdef RX_PARITY_EN
         perr_r <= 1'b0;
`endif
         case (state)
            IDLE: begin
               tick_cnt <= '0;
               bit_cnt  <= '0;
               busy_r   <= ~rx_s;
               if (!rx_s) state <= START;
            end
            START: begin
               if (tick_cnt == MID_TICK) begin
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
`ifdef RX_PARITY_EN
                  par_acc  <= 1'b0;
`endif
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     state  <= IDLE;
                     busy_r <= 1'b0;
                  end
               end else begin
                  tick_cnt <= tick_cnt + TW'(1);
               end
            end
            DATA: begin
               if (tick_cnt == LAST_TICK) begin
                  tick_cnt <= '0;
                  en_r     <= 1'b1;
                  sdata_r  <= rx_s;
`ifdef RX_PARITY_EN
                  par_acc  <= par_acc ^ rx_s;
`endif
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
`ifdef RX_PARITY_EN
                     state   <= PARITY;
`else
                     state   <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  tick_cnt <= tick_cnt + TW'(1);
               end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
               if (tick_cnt == LAST_TICK) begin
                  tick_cnt <= '0;
                  par_bad  <= par_acc ^ rx_s;
                  state    <= STOP;
               end else begin
                  tick_cnt <= tick_cnt + TW'(1);
               end
            end
`endif
            STOP: begin
               if (tick_cnt == LAST_TICK) begin
                  tick_cnt <= '0;
                  state    <= IDLE;
                  // A low line here means IDLE restarts at once, so busy never drops for it.
                  busy_r   <= ~rx_s;
                  if (rx_s) begin
`ifdef RX_PARITY_EN
                     if (par_bad) perr_r <= 1'b1;
                     else         char_r <= 1'b1;
`else
                     char_r <= 1'b1;
`endif
                  end else begin
                     ferr_r <= 1'b1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rx.sdata       = sdata_r;
   assign rx.en          = en_r;
   assign rx.charReceive = char_r;
   assign rx.busy        = busy_r;
   assign rx.frameErr    = ferr_r;
`ifdef RX_PARITY_EN
   assign rx.parErr      = perr_r;
`else
   assign rx.parErr      = 1'b0;
`endif
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the serial-to-parallel shift register in the UART receive path. It watches the raw serial line, detects and validates the start bit, and paces the frame at bit-period granularity. It emits one shift-enable pulse per data bit, centred in the bit, together with the sampled bit value. It then checks the stop bit and either commits the character with a load strobe or flags a framing error.

## Interface

- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; must be ≥4 and even.
- `DATA_BITS`, 8: data bits per frame; must match the shift register width.
- `clk` input, 1: system clock; all state is updated on the rising edge.
- `reset` input, 1: asynchronous, active-high; clears all state immediately.
- `serin` input, 1: raw serial line; idle-high, asynchronous to `clk`.
- `sdata` output, 1: sampled bit value; connects to the shift register serial input.
- `en` output, 1: one-cycle shift strobe, valid with `sdata`.
- `charReceive` output, 1: one-cycle load strobe; the shift register copies its contents to the parallel output.
- `busy` output, 1: high while a frame is in progress (any state other than IDLE).
- `frameErr` output, 1: one-cycle pulse when the stop bit is sampled low.
- `parErr` output, 1: one-cycle parity-failure pulse; tied 0 when `RX_PARITY_EN` is undefined.

## Operation

- **Input synchronisation:** `serin` passes through a 2-flop synchroniser (`rx_s`). All decisions use `rx_s`.
- **Counters:**
  - `tick_cnt` counts 0..`CLKS_PER_BIT`-1.
  - `bit_cnt` counts 0..`DATA_BITS`-1.
- **IDLE:** counters are held at 0. When `rx_s`==0, go to START with `tick_cnt`=0.
- **START:** when `tick_cnt` reaches `CLKS_PER_BIT`/2-1 (mid-bit):
  - If `rx_s`==0: go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
  - If `rx_s`==1: false start; return to IDLE with no strobes.
- **DATA:** when `tick_cnt` reaches `CLKS_PER_BIT`-1:
  - `en` pulses, `sdata` takes `rx_s`, and `bit_cnt` increments.
  - After bit `DATA_BITS`-1, go to PARITY if enabled, otherwise to STOP.
- **PARITY** (only with `RX_PARITY_EN`): samples mid-bit in the same way. The running XOR of the data bits XOR the parity bit must equal 0 (even parity); the result is latched and the state goes to STOP.
- **STOP:** samples at mid-bit.
  - If `rx_s`==1 and there is no parity fault: `charReceive` pulses.
  - If `rx_s`==1 with a parity fault: `parErr` pulses instead of `charReceive`.
  - If `rx_s`==0: `frameErr` pulses and `charReceive` is suppressed.
  - In all cases, go to IDLE.
- **Strobe exclusivity:** `en` and `charReceive` are never high in the same cycle. The downstream shift register gives `en` priority, so overlap would lose the character.
- **Bit order:** no reordering. The first bit received is the first bit shifted in.

## Timing

- **Reset values:** all outputs are 0 on reset. The state is IDLE, both counters are 0, and the synchroniser flops are 1.
- **Detection latency:** the start edge on `serin` is seen 2–3 cycles later on `rx_s`.
- **Data-bit strobes:**
  - The first `en` comes `CLKS_PER_BIT`/2 + `CLKS_PER_BIT` cycles after START entry.
  - Subsequent `en` pulses are spaced exactly `CLKS_PER_BIT` cycles apart.
- **Stop strobe:** `charReceive` (or `frameErr`) comes `CLKS_PER_BIT` cycles after the last data or parity sample.
- **Outputs:** all outputs are registered, with no combinational path from `serin`. `sdata` is stable in the cycle `en` is high.
- **Back-to-back frames:** a new start bit may begin the cycle after the STOP sample. IDLE checks `rx_s` in its first cycle, so there is no dead time.
- **Break condition:** if `serin` is held low through the stop bit, `frameErr` pulses and IDLE then re-enters START immediately. `busy` stays high.
- **Reset mid-frame:** the frame is aborted at once and no strobe is issued for it.

## Configuration

- **`RX_PARITY_EN` defined:**
  - The PARITY state is added, so a frame is start + `DATA_BITS` + parity + stop.
  - `parErr` is live.
  - A parity fault suppresses `charReceive`.
- **`RX_PARITY_EN` undefined:**
  - There is no PARITY state.
  - `parErr` is a constant 0.
  - The frame is start + `DATA_BITS` + stop.

## Test plan

All scenarios use `CLKS_PER_BIT`=16 and `DATA_BITS`=8.

- **Reset mid-frame:** assert `reset` partway through DATA → all outputs 0 in the same cycle. After release, a clean frame decodes correctly.
- **Valid frame:** line sequence 0, 0,1,1,0,0,1,1,0, 1, each bit 16 cycles → exactly 8 `en` pulses 16 cycles apart, `sdata` sequence 01100110, one `charReceive` 16 cycles after the 8th `en`, and `frameErr`=0.
- **Glitch rejection:** a 5-cycle low pulse on an idle line → START is entered and IDLE is returned to. No `en`, `charReceive` or `frameErr`; `busy` is high for ≤10 cycles.
- **Framing error:** a valid data pattern with the stop bit held low → `frameErr` pulses once, `charReceive` stays 0, and the controller re-enters START.
- **Back-to-back frames:** two frames with no idle gap (0xA5, then 0x3C) → 16 `en` pulses and 2 `charReceive` pulses, never coincident with `en`.
- **Parity (`RX_PARITY_EN`):** data 0x07 with parity bit 1 → `charReceive`. The same data with parity bit 0 → `parErr`=1 and `charReceive`=0.
